// File: rtl/divu_hilo_pkg.sv
// ============================================================================
// Module : divu_hilo_pkg
// Shared state encodings, default width and Hi/Lo read-select codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package divu_hilo_pkg;

  localparam int DIVU_WIDTH = 32;

  // Divider FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // HiorLo read-select encodings
  localparam logic SEL_HI = 1'b1;
  localparam logic SEL_LO = 1'b0;

endpackage : divu_hilo_pkg

`default_nettype wire

// File: rtl/divu_hilo_step.sv
// ============================================================================
// Module : divu_step
// One combinational restoring-division step on a WIDTH+1-bit compare path.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // Extra MSB keeps the carried-out bit of the shifted remainder visible.
  assign w_shifted = {rem_i, quo_i[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, divisor_i};
  assign w_fits    = (w_shifted >= {1'b0, divisor_i});

  assign rem_o = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], w_fits};

endmodule : divu_step

`default_nettype wire

// File: rtl/divu_hilo.sv
// ============================================================================
// Module : divu_hilo
// Multi-cycle unsigned divider committing remainder/quotient into Hi/Lo.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module divu_hilo
  import divu_hilo_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             HiLo_ctrl,
  input  logic             HiorLo,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  divu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (w_step_rem),
    .quo_o     (w_step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!div_rst) begin
          rem_d   = '0;
          quo_d   = dividend;
          dvs_d   = divisor;
          dbz_d   = (divisor == '0);
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (div_rst) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          rem_d = w_step_rem;
          quo_d = w_step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST_STEP) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Abort takes priority so a late commit can never slip through.
        if (div_rst) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (HiLo_ctrl) begin
          hi_d = rem_q;
          lo_d = quo_q;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    hilo_out = lo_q;
    case (HiorLo)
      SEL_HI:  hilo_out = hi_q;
      SEL_LO:  hilo_out = lo_q;
      default: hilo_out = lo_q;
    endcase
  end

  // The load cycle counts as busy, but not while reset is holding the FSM.
  assign busy        = (state_q == ST_RUN) ||
                       ((state_q == ST_IDLE) && !div_rst && rst_n);
  assign done        = (state_q == ST_DONE);
  assign div_by_zero = dbz_q;

endmodule : divu_hilo

`default_nettype wire

// File: tb/tb_divu_hilo.sv
// ============================================================================
// Module : tb_divu_hilo
// Directed self-checking bench for divu_hilo with hand-computed results.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_divu_hilo;

  logic        clk;
  logic        rst_n;
  logic        div_rst;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        HiLo_ctrl;
  logic        HiorLo;
  logic [31:0] hilo_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  divu_hilo #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_rst     (div_rst),
    .dividend    (dividend),
    .divisor     (divisor),
    .HiLo_ctrl   (HiLo_ctrl),
    .HiorLo      (HiorLo),
    .hilo_out    (hilo_out),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    HiorLo = 1'b0;
    #1;
    check_eq({tag, " lo"}, hilo_out, exp_lo);
    HiorLo = 1'b1;
    #1;
    check_eq({tag, " hi"}, hilo_out, exp_hi);
    HiorLo = 1'b0;
  endtask

  // Entry: div_rst=1, one tick after an edge. Exit: one rearm gap cycle done.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    check_eq({tag, " idle done"}, {31'd0, done}, 32'd0);
    dividend = a;
    divisor  = b;
    div_rst  = 1'b0;
    #1;
    check_eq({tag, " load busy"}, {31'd0, busy}, 32'd1);
    tick();
    check_eq({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, (b == 32'd0)});
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0BAD_F00D;
    repeat (31) tick();
    check_eq({tag, " c32 done"}, {31'd0, done}, 32'd0);
    tick();
    check_eq({tag, " c33 done"}, {31'd0, done}, 32'd1);
    check_eq({tag, " c33 busy"}, {31'd0, busy}, 32'd0);
    HiLo_ctrl = 1'b1;
    read_hilo({tag, " c33 old"}, model_hi, model_lo);
    tick();
    HiLo_ctrl = 1'b0;
    model_hi  = exp_hi;
    model_lo  = exp_lo;
    read_hilo({tag, " c34"}, exp_hi, exp_lo);
    div_rst = 1'b1;
    tick();
    check_eq({tag, " gap done"}, {31'd0, done}, 32'd0);
    check_eq({tag, " gap busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    div_rst   = 1'b1;
    dividend  = 32'd0;
    divisor   = 32'd0;
    HiLo_ctrl = 1'b0;
    HiorLo    = 1'b0;
    #12;
    read_hilo("reset", 32'd0, 32'd0);
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    check_eq("reset dbz",  {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    run_div("basic", 32'd100, 32'd7, 32'd2, 32'd14);
    run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
    run_div("5/max", 32'd5, 32'hFFFF_FFFF, 32'd5, 32'd0);
    run_div("dbz", 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);

    // Async reset between edges while a divide-by-zero is in flight
    dividend = 32'd7;
    divisor  = 32'd0;
    div_rst  = 1'b0;
    repeat (5) tick();
    check_eq("pre-rst dbz", {31'd0, div_by_zero}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    read_hilo("async rst", 32'd0, 32'd0);
    check_eq("async rst busy", {31'd0, busy}, 32'd0);
    check_eq("async rst done", {31'd0, done}, 32'd0);
    check_eq("async rst dbz",  {31'd0, div_by_zero}, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(posedge clk);
    #1;
    div_rst = 1'b1;
    rst_n   = 1'b1;
    tick();
    check_eq("post-rst busy", {31'd0, busy}, 32'd0);
    run_div("post-rst", 32'd1000, 32'd33, 32'd10, 32'd30);

    // Abort: preload Hi/Lo = 9/3, then kill 100/7 at cycle 10
    run_div("preload", 32'd39, 32'd10, 32'd9, 32'd3);
    dividend = 32'd100;
    divisor  = 32'd7;
    div_rst  = 1'b0;
    repeat (10) tick();
    div_rst = 1'b1;
    #1;
    check_eq("abort c10 busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("abort idle busy", {31'd0, busy}, 32'd0);
    check_eq("abort idle done", {31'd0, done}, 32'd0);
    HiLo_ctrl = 1'b1;
    tick();
    HiLo_ctrl = 1'b0;
    read_hilo("abort keep", 32'd9, 32'd3);

    // Back-to-back with a single rearm cycle between them
    run_div("b2b first", 32'd100, 32'd7, 32'd2, 32'd14);
    run_div("b2b second", 32'd81, 32'd9, 32'd0, 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_divu_hilo

`default_nettype wire
